// File: rtl/serial_mag_compare_pkg.sv
// Shared types and helpers for the serial magnitude comparator.
// The state enum, the slice width and the slice-count helper live here.
package serial_cmp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int SLICE_W = 2;

    function automatic int nslice(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/serial_mag_compare_if.sv
// Request/result bundle between a requester and the serial magnitude comparator.
// The requester drives start and the operands; the comparator returns busy, done and the held flags.
interface serial_mag_compare_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             a_eq_b;
    logic             a_gt_b;
    logic             a_lt_b;

    modport master (
        output start, a, b,
        input  busy, done, a_eq_b, a_gt_b, a_lt_b
    );

    modport slave (
        input  start, a, b,
        output busy, done, a_eq_b, a_gt_b, a_lt_b
    );
endinterface

// File: rtl/serial_mag_compare_cmp2.sv
// Gate-level 2-bit unsigned magnitude comparator cell.
// Exactly one of eq/gt/lt is high for any input pair.
module comparator_2bit (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       eq,
    output logic       gt,
    output logic       lt
);
    logic eqHi;
    logic eqLo;

    assign eqHi = ~(a[1] ^ b[1]);
    assign eqLo = ~(a[0] ^ b[0]);

    assign eq = eqHi & eqLo;
    assign gt = (a[1] & ~b[1]) | (eqHi & a[0] & ~b[0]);
    assign lt = (~a[1] & b[1]) | (eqHi & ~a[0] & b[0]);
endmodule

// File: rtl/serial_mag_compare.sv
// Sequential WIDTH-bit unsigned comparator: walks 2-bit slices MSB first through one
// comparator_2bit cell and stops at the first unequal slice.
//
//  state | meaning
//  IDLE  | waiting for start; result flags held from the last comparison
//  RUN   | comparing the top slice of the shift registers each cycle
module serial_mag_compare
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_mag_compare_if.slave  cmpBus
);
    localparam int NSLICE = nslice(WIDTH);
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_t           state;
    logic [WIDTH-1:0] shiftA;
    logic [WIDTH-1:0] shiftB;
    logic [CNT_W-1:0] sliceCnt;
    logic             busyReg;
    logic             doneReg;
    logic             eqReg;
    logic             gtReg;
    logic             ltReg;

    logic             sliceEq;
    logic             sliceGt;
    logic             sliceLt;

    comparator_2bit u_cmp (
        .a  (shiftA[WIDTH-1 -: SLICE_W]),
        .b  (shiftB[WIDTH-1 -: SLICE_W]),
        .eq (sliceEq),
        .gt (sliceGt),
        .lt (sliceLt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            shiftA   <= '0;
            shiftB   <= '0;
            sliceCnt <= '0;
            busyReg  <= 1'b0;
            doneReg  <= 1'b0;
            eqReg    <= 1'b0;
            gtReg    <= 1'b0;
            ltReg    <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmpBus.start && !busyReg) begin
                        shiftA   <= cmpBus.a;
                        shiftB   <= cmpBus.b;
                        sliceCnt <= CNT_W'(NSLICE - 1);
                        eqReg    <= 1'b0;
                        gtReg    <= 1'b0;
                        ltReg    <= 1'b0;
                        busyReg  <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    // First unequal slice decides the whole result.
                    if (!sliceEq) begin
                        gtReg   <= sliceGt;
                        ltReg   <= sliceLt;
                        doneReg <= 1'b1;
                        busyReg <= 1'b0;
                        state   <= IDLE;
                    end else if (sliceCnt != '0) begin
                        shiftA   <= shiftA << SLICE_W;
                        shiftB   <= shiftB << SLICE_W;
                        sliceCnt <= sliceCnt - 1'b1;
                    end else begin
                        eqReg   <= 1'b1;
                        doneReg <= 1'b1;
                        busyReg <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    busyReg <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign cmpBus.busy   = busyReg;
    assign cmpBus.done   = doneReg;
    assign cmpBus.a_eq_b = eqReg;
    assign cmpBus.a_gt_b = gtReg;
    assign cmpBus.a_lt_b = ltReg;
endmodule

// File: tb/tb_serial_mag_compare.sv
// Directed bench for serial_mag_compare: a reference model pushes the expected flags and
// decision slice when a comparison is started; they are popped when done is observed.
module tb_serial_mag_compare;
    import serial_cmp_pkg::*;

    localparam int WIDTH = 8;
    localparam int NS    = WIDTH / 2;

    typedef struct {
        logic eq;
        logic gt;
        logic lt;
        int   k;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   nCmp  = 0;
    int   nFail = 0;
    exp_t sb[$];

    serial_mag_compare_if #(.WIDTH(WIDTH)) cmpBus ();

    serial_mag_compare #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cmpBus (cmpBus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        exp_t e;
        bit   found;
        e.k   = NS;
        found = 1'b0;
        for (int s = 1; s <= NS; s++) begin
            if (!found && (x[WIDTH-2*s +: 2] != y[WIDTH-2*s +: 2])) begin
                e.k   = s;
                found = 1'b1;
            end
        end
        e.eq = (x == y);
        e.gt = (x > y);
        e.lt = (x < y);
        return e;
    endfunction

    function automatic logic [2:0] flags();
        return {cmpBus.a_eq_b, cmpBus.a_gt_b, cmpBus.a_lt_b};
    endfunction

    // Drives an accepted start; returns in the cycle after edge t.
    task automatic startCmp(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        cmpBus.start = 1'b1;
        cmpBus.a     = x;
        cmpBus.b     = y;
        sb.push_back(model(x, y));
        tick();
        cmpBus.start = 1'b0;
        check({tag, ".busy_start"}, 32'(cmpBus.busy), 32'd1);
        check({tag, ".flags_clear"}, 32'(flags()), 32'd0);
    endtask

    // Counts edges from t until done; returns in the done cycle.
    task automatic waitResult(input string tag);
        exp_t e;
        int   edges;
        edges = 0;
        e     = sb.pop_front();
        do begin
            tick();
            edges++;
        end while (cmpBus.done !== 1'b1 && edges < 3 * NS);
        check({tag, ".done"}, 32'(cmpBus.done), 32'd1);
        check({tag, ".latency"}, 32'(edges), 32'(e.k));
        check({tag, ".flags"}, 32'(flags()), 32'({e.eq, e.gt, e.lt}));
        check({tag, ".busy_done"}, 32'(cmpBus.busy), 32'd0);
    endtask

    task automatic runCmp(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [2:0] held;
        startCmp(tag, x, y);
        waitResult(tag);
        held = flags();
        tick();
        check({tag, ".done_pulse"}, 32'(cmpBus.done), 32'd0);
        check({tag, ".flags_held"}, 32'(flags()), 32'(held));
    endtask

    initial begin
        exp_t junk;
        bit   sawDone;

        cmpBus.start = 1'b0;
        cmpBus.a     = '0;
        cmpBus.b     = '0;
        rst_n        = 1'b0;
        repeat (3) tick();
        check("reset.busy", 32'(cmpBus.busy), 32'd0);
        check("reset.done", 32'(cmpBus.done), 32'd0);
        check("reset.flags", 32'(flags()), 32'd0);
        rst_n = 1'b1;
        tick();

        runCmp("eq_a5", 8'hA5, 8'hA5);
        runCmp("gt_msb", 8'h80, 8'h7F);
        runCmp("lt_lsb", 8'h34, 8'h36);
        runCmp("gt_lsb", 8'hFF, 8'hFE);
        runCmp("lt_msb", 8'h40, 8'h80);
        runCmp("gt_mid", 8'h0C, 8'h08);
        runCmp("eq_zero", 8'h00, 8'h00);

        // Start while busy is ignored; operand changes during RUN are harmless.
        startCmp("ign", 8'h00, 8'hFF);
        cmpBus.start = 1'b1;
        cmpBus.a     = 8'hFF;
        cmpBus.b     = 8'h00;
        waitResult("ign");
        cmpBus.start = 1'b0;
        cmpBus.a     = 8'h3C;
        cmpBus.b     = 8'hC3;
        tick();
        check("ign.busy_after", 32'(cmpBus.busy), 32'd0);
        check("ign.flags_after", 32'(flags()), 32'b001);
        cmpBus.a = 8'h99;
        tick();
        check("ign.busy_idle", 32'(cmpBus.busy), 32'd0);

        // Reset mid-comparison aborts without a done pulse.
        startCmp("abort", 8'h12, 8'h12);
        junk = sb.pop_back();
        tick();
        rst_n = 1'b0;
        tick();
        check("abort.busy", 32'(cmpBus.busy), 32'd0);
        check("abort.flags", 32'(flags()), 32'd0);
        check("abort.done", 32'(cmpBus.done), 32'd0);
        rst_n   = 1'b1;
        sawDone = 1'b0;
        for (int i = 0; i < 2 * NS; i++) begin
            tick();
            if (cmpBus.done === 1'b1) sawDone = 1'b1;
        end
        check("abort.no_done", 32'(sawDone), 32'd0);

        // Back-to-back: second start lands in the done cycle of the first.
        startCmp("b2b1", 8'h55, 8'h54);
        waitResult("b2b1");
        startCmp("b2b2", 8'h01, 8'h02);
        waitResult("b2b2");
        tick();
        check("b2b2.done_pulse", 32'(cmpBus.done), 32'd0);
        check("b2b2.flags_held", 32'(flags()), 32'b001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end
endmodule

// File: doc/serial_mag_compare.md
# serial_mag_compare

Sequential WIDTH-bit magnitude comparator built around the team's 2-bit gate-level comparator cell (`comparator_2bit`). It captures two operands on a start strobe and feeds one 2-bit slice pair per cycle, MSB first, into the cell. It consumes the cell's equal/greater/less flags, terminates early on the first unequal slice, and presents a registered, held result with a done pulse. It sits directly downstream of the comparator cell and acts as its sequencing and result-accumulation stage.

## Interface
- WIDTH, 8, operand width; must be even and ≥ 2; NSLICE = WIDTH/2
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  request; accepted only when busy=0
- a  in  WIDTH  operand A, sampled on accepted start only
- b  in  WIDTH  operand B, sampled on accepted start only
- busy  out  1  comparison in progress
- done  out  1  one-cycle pulse, result valid
- a_eq_b  out  1  A == B, held until next accepted start
- a_gt_b  out  1  A > B, held until next accepted start
- a_lt_b  out  1  A < B, held until next accepted start

## Operation
- States: IDLE, RUN.
- IDLE to RUN on an accepted start (start=1 and busy=0):
  - a and b load into shift registers sa and sb.
  - Slice counter loads NSLICE-1.
  - All three result flags clear to 0.
- In RUN, the cell compares sa[WIDTH-1:WIDTH-2] with sb[WIDTH-1:WIDTH-2] combinationally.
- RUN, slice unequal (cell gt or lt high):
  - The matching flag is registered.
  - done=1 for the next cycle.
  - State goes to IDLE.
- RUN, slice equal, counter > 0: sa and sb shift left by 2, counter decrements, state stays RUN.
- RUN, slice equal, counter = 0: a_eq_b=1, done=1, state goes to IDLE.
- After done, exactly one flag is high. Before any comparison completes, all flags are 0.
- start while busy=1 is ignored; a and b changes during RUN have no effect.
- Unsigned comparison only.

## Timing
- Reset values:
  - state IDLE.
  - busy, done, a_eq_b, a_gt_b, a_lt_b all 0.
  - Shift registers and counter 0.
- rst_n low during RUN aborts the comparison: no done pulse, flags 0 on the following cycle.
- Let edge t be the edge that samples an accepted start:
  - busy=1 from t.
  - The first differing slice is k (MSB slice k=1); if operands are equal, k=NSLICE.
  - The flags and done=1 appear after edge t+k. busy=0 in that same cycle.
- Latency: best case 1 cycle, worst case NSLICE cycles.
- done is high for exactly one cycle.
- start may be high in the done cycle; it is accepted because busy=0. Flags clear at that edge, giving back-to-back throughput of one comparison per k+1 cycles.
- Counter width: max(1, $clog2(NSLICE)).

## Structure
- Shared package serial_cmp_pkg holds:
  - the state enum (IDLE, RUN);
  - SLICE_W = 2;
  - a function nslice(width) returning width/2.
- One sub-module: `comparator_2bit`, instantiated once. It is driven from the top slices of the shift registers; its outputs feed the FSM.
- FSM, counter, shift registers and result registers live in the top module.

## Test plan
- WIDTH=8, a=0xA5, b=0xA5, start one cycle -> busy for 4 cycles; done pulse after edge t+4 with a_eq_b=1, a_gt_b=0, a_lt_b=0.
- a=0x80, b=0x7F -> MSB slice 10 vs 01 decides; done after edge t+1 with a_gt_b=1 and the other flags 0.
- a=0x34, b=0x36 -> slices 1-3 equal, slice 4 is 00 vs 10; done after edge t+4 with a_lt_b=1.
- Start a=0x00, b=0xFF; in the following cycle pulse start with a=0xFF, b=0x00 and change a and b every cycle -> second start ignored; result a_lt_b=1 after edge t+1.
- a=0x12, b=0x12, rst_n low at edge t+2 -> busy=0 and all flags 0 next cycle; done never pulses.
- In the done cycle of 0x55 vs 0x54, assert start with a=0x01, b=0x02 -> first result a_gt_b=1 with done at edge t+4; at that edge flags clear, busy=1, second result a_lt_b=1 after 4 further edges.
